// File: rtl/rr_arb_8_if.sv
// Bus between the round-robin arbiter and its eight requesters plus the
// shared resource: requests and completion in, grant/select/status out.
interface rr_arb_8_if;
   logic [7:0] req;
   logic       done;
   logic [7:0] grant;
   logic [2:0] select;
   logic       busy;
   logic       timeout;

   // The requester/resource side drives req/done and observes the arbiter.
   modport master (
      output req, done,
      input  grant, select, busy, timeout
   );

   // The arbiter side.
   modport slave (
      input  req, done,
      output grant, select, busy, timeout
   );
endinterface

// File: rtl/rr_arb_8.sv
// Eight-way round-robin arbiter for a shared resource. A grant is held until
// the resource reports done, the owner drops its request, or the optional
// hold limit expires. The priority pointer moves past the last owner, and an
// IDLE cycle always separates two grants.
module rr_arb_8 #(
   parameter int unsigned MAX_HOLD = 16
) (
   input logic       clk,
   input logic       rst_n,
   rr_arb_8_if.slave bus
);

   typedef enum logic {IDLE, BUSY} state_t;

   localparam bit         HOLD_EN   = (MAX_HOLD != 0);
   localparam logic [7:0] HOLD_LAST = HOLD_EN ? 8'(MAX_HOLD - 1) : 8'd0;

   state_t     state, state_nxt;
   logic [2:0] ptr, ptr_nxt;
   logic [7:0] hcnt, hcnt_nxt;
   logic [7:0] grant_r, grant_nxt;
   logic [2:0] sel_r, sel_nxt;
   logic       busy_r, busy_nxt;
   logic       to_r, to_nxt;

   logic       found;
   logic [2:0] win;
   logic       hold_hit;
   logic       release_now;

   // Find the first requester scanning circularly from ptr upwards.
   always_comb begin
      found = 1'b0;
      win   = ptr;
      for (int i = 0; i < 8; i++) begin
         logic [2:0] idx;
         idx = ptr + 3'(i);
         if (!found && bus.req[idx]) begin
            found = 1'b1;
            win   = idx;
         end
      end
   end

   assign hold_hit    = HOLD_EN && (hcnt == HOLD_LAST);
   assign release_now = bus.done || !bus.req[sel_r] || hold_hit;

   // Next-state and next-output logic for the IDLE/BUSY controller.
   always_comb begin
      // NOTE: every target gets a default first so no path leaves it unassigned
      // and infers a latch.
      state_nxt = state;
      ptr_nxt   = ptr;
      hcnt_nxt  = hcnt;
      grant_nxt = grant_r;
      sel_nxt   = sel_r;
      busy_nxt  = busy_r;
      to_nxt    = 1'b0;
      case (state)
         IDLE: begin
            if (found) begin
               state_nxt = BUSY;
               grant_nxt = 8'd1 << win;
               sel_nxt   = win;
               busy_nxt  = 1'b1;
               hcnt_nxt  = 8'd0;
            end
         end
         BUSY: begin
            if (release_now) begin
               state_nxt = IDLE;
               grant_nxt = 8'd0;
               busy_nxt  = 1'b0;
               ptr_nxt   = sel_r + 3'd1;
               hcnt_nxt  = 8'd0;
               // Only a pure hold-limit revocation is reported as a timeout.
               to_nxt    = hold_hit && !bus.done && bus.req[sel_r];
            end else if (hcnt != 8'hFF) begin
               hcnt_nxt = hcnt + 8'd1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State and registered outputs; reset clears everything asynchronously.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         ptr     <= 3'd0;
         hcnt    <= 8'd0;
         grant_r <= 8'd0;
         sel_r   <= 3'd0;
         busy_r  <= 1'b0;
         to_r    <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples the
         // pre-edge values, independent of statement order.
         state   <= state_nxt;
         ptr     <= ptr_nxt;
         hcnt    <= hcnt_nxt;
         grant_r <= grant_nxt;
         sel_r   <= sel_nxt;
         busy_r  <= busy_nxt;
         to_r    <= to_nxt;
      end
   end

   assign bus.grant   = grant_r;
   assign bus.select  = sel_r;
   assign bus.busy    = busy_r;
   assign bus.timeout = to_r;

endmodule

// File: tb/tb_rr_arb_8.sv
// Testbench for rr_arb_8: directed scenarios followed by random traffic,
// every cycle compared against a transaction-level model of the arbiter.
module tb_rr_arb_8;

   localparam int HOLD = 4;

   logic clk;
   logic rst_n;
   int   n_chk;
   int   n_err;

   rr_arb_8_if bus ();

   rr_arb_8 #(.MAX_HOLD(HOLD)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Model: the owner index (-1 when nobody owns), the requester that has
   // priority next, the number of BUSY cycles the owner has had, the last
   // owner index, and whether the last release was a pure timeout.
   int   m_owner;
   int   m_ptr;
   int   m_cnt;
   int   m_sel;
   logic m_to;

   task automatic model_reset();
      m_owner = -1;
      m_ptr   = 0;
      m_cnt   = 0;
      m_sel   = 0;
      m_to    = 1'b0;
   endtask

   task automatic model_edge(input logic [7:0] r, input logic d);
      bit lim;
      m_to = 1'b0;
      if (m_owner < 0) begin
         for (int k = 0; k < 8; k++) begin
            int c;
            c = (m_ptr + k) % 8;
            if (m_owner < 0 && r[c]) m_owner = c;
         end
         if (m_owner >= 0) begin
            m_cnt = 1;
            m_sel = m_owner;
         end
      end else begin
         lim = (HOLD != 0) && (m_cnt == HOLD);
         if (d || !r[m_owner] || lim) begin
            m_to    = lim && !d && r[m_owner];
            m_ptr   = (m_owner + 1) % 8;
            m_owner = -1;
         end else begin
            m_cnt++;
         end
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_model(input string tag);
      logic [7:0] eg;
      eg = (m_owner >= 0) ? 8'(1 << m_owner) : 8'h00;
      check({tag, ".grant"},   32'(bus.grant),   32'(eg));
      check({tag, ".select"},  32'(bus.select),  32'(m_sel));
      check({tag, ".busy"},    32'(bus.busy),    32'(m_owner >= 0));
      check({tag, ".timeout"}, 32'(bus.timeout), 32'(m_to));
   endtask

   // Drive inputs for one cycle, advance the model on the edge, then compare.
   task automatic step(input string tag, input logic [7:0] r, input logic d);
      bus.req  = r;
      bus.done = d;
      @(posedge clk);
      model_edge(r, d);
      #1;
      check_model(tag);
   endtask

   initial begin
      logic [7:0] rr;
      logic       dd;
      clk      = 1'b0;
      rst_n    = 1'b0;
      n_chk    = 0;
      n_err    = 0;
      bus.req  = 8'h00;
      bus.done = 1'b0;
      model_reset();

      // Reset state before any clock edge.
      #3;
      check_model("reset");
      @(posedge clk);
      #1;
      check_model("reset_edge");
      rst_n = 1'b1;

      // Idle with no request; done in IDLE is ignored.
      step("idle_done", 8'h00, 1'b1);
      step("idle_done", 8'h00, 1'b1);

      // Single request, then done; pointer moves to 5.
      step("single", 8'h10, 1'b0);
      check("single_grant", 32'(bus.grant), 32'h10);
      check("single_sel", 32'(bus.select), 32'd4);
      step("single_done", 8'h10, 1'b1);
      check("single_release", 32'(bus.grant), 32'h00);
      step("ptr5", 8'h30, 1'b0);
      check("ptr5_sel", 32'(bus.select), 32'd5);
      step("ptr5_rel", 8'h30, 1'b1);

      // Reach ptr = 7, then wrap-around between bits 7 and 0.
      step("to_ptr7", 8'h40, 1'b0);
      step("to_ptr7", 8'h40, 1'b1);
      step("wrap_hi", 8'h81, 1'b0);
      check("wrap_hi_grant", 32'(bus.grant), 32'h80);
      step("wrap_hi_rel", 8'h81, 1'b1);
      step("wrap_lo", 8'h81, 1'b0);
      check("wrap_lo_grant", 32'(bus.grant), 32'h01);
      step("wrap_lo_rel", 8'h81, 1'b1);

      // Owner 3 drops its request mid-BUSY; pointer moves to 4.
      step("drop", 8'h08, 1'b0);
      step("drop", 8'h08, 1'b0);
      step("drop_rel", 8'h00, 1'b0);
      check("drop_grant", 32'(bus.grant), 32'h00);
      check("drop_to", 32'(bus.timeout), 32'd0);
      step("drop_ptr4", 8'h18, 1'b0);
      check("drop_ptr4_sel", 32'(bus.select), 32'd4);
      step("drop_ptr4_rel", 8'h18, 1'b1);

      // Hold limit: busy for HOLD cycles, then a one-cycle timeout pulse.
      for (int i = 0; i < HOLD; i++) begin
         step("hold", 8'h02, 1'b0);
         check("hold_busy", 32'(bus.busy), 32'd1);
      end
      step("hold_limit", 8'h02, 1'b0);
      check("hold_limit_grant", 32'(bus.grant), 32'h00);
      check("hold_limit_to", 32'(bus.timeout), 32'd1);
      step("hold_regrant", 8'h02, 1'b0);
      check("hold_pulse_end", 32'(bus.timeout), 32'd0);
      for (int i = 1; i < HOLD; i++) step("hold2", 8'h02, 1'b0);
      step("hold_done_limit", 8'h02, 1'b1);
      check("hold_done_to", 32'(bus.timeout), 32'd0);
      check("hold_done_busy", 32'(bus.busy), 32'd0);
      step("hold_clear", 8'h00, 1'b0);

      // Fairness from reset: all requesting, done every cycle.
      rst_n = 1'b0;
      model_reset();
      #1;
      check_model("reset2");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int j = 0; j < 17; j++) begin
         step("fair", 8'hFF, 1'b1);
         if (j % 2 == 0) begin
            check("fair_sel", 32'(bus.select), 32'((j / 2) % 8));
            check("fair_busy", 32'(bus.busy), 32'd1);
         end else begin
            check("fair_bubble", 32'(bus.busy), 32'd0);
         end
      end

      // Asynchronous reset between edges while BUSY.
      step("async_busy", 8'hFF, 1'b0);
      #3;
      rst_n = 1'b0;
      #1;
      model_reset();
      check("async_grant", 32'(bus.grant), 32'h00);
      check("async_busy", 32'(bus.busy), 32'd0);
      check_model("async");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      step("async_first", 8'hFF, 1'b0);
      check("async_first_grant", 32'(bus.grant), 32'h01);
      step("async_first_rel", 8'hFF, 1'b1);

      // Random traffic: requests mostly held stable so hold limits occur.
      rr = 8'h3C;
      for (int n = 0; n < 400; n++) begin
         if ($urandom_range(0, 3) == 0) rr = 8'($urandom) & 8'($urandom);
         dd = ($urandom_range(0, 5) == 0);
         step("rand", rr, dd);
         check("rand_onehot", 32'($countones(bus.grant) <= 1), 32'd1);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
